video_in_write: RTL and testbench

//  Capture-side counterpart of the video output path: samples an 8-bit pixel stream

---
 rtl/video_in_write.sv | 215 +++++++++++++++++++++
 tb/tb_video_in_write.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_in_write.sv
// Pixel capture path: packs 8-bit pixels four per word, buffers words in a FIFO
// and bursts them to a frame buffer over a Wishbone master port.
module video_in_write #(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        pixel_en,
  input  logic        frame_valid,
  input  logic        line_valid,
  input  logic [7:0]  pixel_in,
  input  logic [31:0] wb_reg_data,
  input  logic [31:0] wb_reg_ctr,
  output logic        interrupt,
  output logic        overflow,
  output logic        p_wb_STB_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_LOCK_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_WE_O,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  input  logic        p_wb_ACK_I
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BURST_C     = CW'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(BURST_LEN - 1);
  localparam logic [31:0]   FRAME_WORDS = 32'(WIDTH * HEIGHT / 4);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t          r_state, w_state_next;
  logic [BW-1:0]   r_beats;

  logic            r_fv_d, r_lv_d;
  logic            r_armed, r_frame_end, r_irq;
  logic [31:0]     r_base;

  logic [31:0]     r_pack;
  logic [1:0]      r_byte_idx;
  logic            r_push_pend;
  logic [31:0]     r_push_data;

  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_word_cnt;
  logic [29:0]     r_word_idx;
  logic            r_overflow;

  logic            w_fv_rise, w_fv_fall, w_lv_fall;
  logic            w_arm, w_active, w_pix, w_flush;
  logic [1:0]      w_idx;
  logic            w_stb, w_pop, w_limit, w_full, w_wr, w_drop, w_irq;
  logic            w_unused_bits;

  assign w_unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};

  assign w_fv_rise = pixel_en && frame_valid && !r_fv_d;
  assign w_fv_fall = pixel_en && !frame_valid && r_fv_d;
  assign w_lv_fall = pixel_en && !line_valid && r_lv_d;

  // A frame may only be armed once the previous armed frame has fully drained.
  assign w_arm    = w_fv_rise && wb_reg_ctr[0] && !r_armed;
  assign w_active = w_arm || (r_armed && !r_frame_end);
  assign w_idx    = w_arm ? 2'd0 : r_byte_idx;
  assign w_pix    = w_active && pixel_en && frame_valid && line_valid;
  assign w_flush  = w_active && (w_lv_fall || w_fv_fall) && (w_idx != 2'd0);

  assign w_stb   = (r_state == S_BURST);
  assign w_pop   = w_stb && p_wb_ACK_I;
  assign w_limit = (r_word_cnt >= FRAME_WORDS);
  assign w_full  = (r_count == DEPTH_C);
  assign w_wr    = r_push_pend && !w_limit && (!w_full || w_pop);
  assign w_drop  = r_push_pend && !w_wr;

  assign w_irq = r_armed && r_frame_end && (r_byte_idx == 2'd0) && !r_push_pend &&
                 (r_count == '0) && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_fv_d <= 1'b0;
      r_lv_d <= 1'b0;
    end else if (pixel_en) begin
      r_fv_d <= frame_valid;
      r_lv_d <= line_valid;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_armed     <= 1'b0;
      r_frame_end <= 1'b0;
      r_base      <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= w_irq;
      if (w_arm) begin
        r_armed     <= 1'b1;
        r_frame_end <= 1'b0;
        r_base      <= {wb_reg_data[31:2], 2'b00};
      end else if (w_irq) begin
        r_armed     <= 1'b0;
        r_frame_end <= 1'b0;
      end else if (r_armed && !r_frame_end && w_fv_fall) begin
        r_frame_end <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_pack      <= '0;
      r_byte_idx  <= '0;
      r_push_pend <= 1'b0;
      r_push_data <= '0;
    end else if (w_pix) begin
      if (w_idx == 2'd3) begin
        r_push_pend <= 1'b1;
        r_push_data <= {pixel_in, r_pack[23:0]};
        r_pack      <= '0;
        r_byte_idx  <= '0;
      end else begin
        r_pack[8*w_idx +: 8] <= pixel_in;
        r_byte_idx  <= w_idx + 2'd1;
        r_push_pend <= 1'b0;
      end
    end else if (w_flush) begin
      // Unfilled bytes are already zero, so the partial word goes out padded.
      r_push_pend <= 1'b1;
      r_push_data <= r_pack;
      r_pack      <= '0;
      r_byte_idx  <= '0;
    end else begin
      r_push_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_push_data;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_word_cnt <= '0;
      r_word_idx <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_arm) begin
        r_word_cnt <= '0;
        r_word_idx <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (r_push_pend && !w_limit) r_word_cnt <= r_word_cnt + 32'd1;
        if (w_pop)  r_word_idx <= r_word_idx + 30'd1;
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_beats <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state != S_BURST) r_beats <= '0;
      else if (w_pop)         r_beats <= r_beats + BW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:
        if (r_count >= BURST_C || (r_armed && r_frame_end && r_count != '0))
          w_state_next = S_BURST;
      S_BURST:
        if (w_pop && (r_beats == LAST_BEAT || (r_count == CW'(1) && !w_wr)))
          w_state_next = S_GAP;
      S_GAP:
        w_state_next = S_IDLE;
      default:
        w_state_next = S_IDLE;
    endcase
  end

  assign p_wb_STB_O  = w_stb;
  assign p_wb_CYC_O  = w_stb;
  assign p_wb_LOCK_O = w_stb;
  assign p_wb_WE_O   = w_stb;
  assign p_wb_SEL_O  = w_stb ? 4'hF : 4'h0;
  assign p_wb_ADR_O  = w_stb ? (r_base + {r_word_idx, 2'b00}) : '0;
  assign p_wb_DAT_O  = w_stb ? r_mem[r_rptr] : '0;
  assign interrupt   = r_irq;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_video_in_write.sv
// Directed bench for video_in_write: frame scenarios from a vector table plus
// hand-written sequences for back-pressure, late enable and mid-burst reset.
module tb_video_in_write;

  localparam int unsigned BL = 8;

  logic        clk = 1'b0;
  logic        nRST;
  logic        pe, fv, lv;
  logic [7:0]  pix;
  logic [31:0] wb_reg_data, wb_reg_ctr;
  logic        irq, ovf, stb, cyc, lock, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat;

  video_in_write #(.WIDTH(8), .HEIGHT(12), .FIFO_DEPTH(16), .BURST_LEN(8)) dut (
    .clk(clk), .nRST(nRST), .pixel_en(pe), .frame_valid(fv), .line_valid(lv),
    .pixel_in(pix), .wb_reg_data(wb_reg_data), .wb_reg_ctr(wb_reg_ctr),
    .interrupt(irq), .overflow(ovf), .p_wb_STB_O(stb), .p_wb_CYC_O(cyc),
    .p_wb_LOCK_O(lock), .p_wb_SEL_O(sel), .p_wb_WE_O(we), .p_wb_ADR_O(adr),
    .p_wb_DAT_O(dat), .p_wb_ACK_I(ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Slave model and bus monitor: 0 = ACK same cycle, 1 = ACK held low, 2 = every 3rd cycle
  int          ack_mode = 0;
  int unsigned tick = 0;
  int          proto_viol = 0, irq_total = 0, full_bursts = 0, ten = 0;
  logic        prev_stb = 1'b0, prev_ack = 1'b0, prev_cyc = 1'b0, prev_irq = 1'b0, ack_n;
  logic [31:0] cap_adr[$];
  logic [31:0] cap_dat[$];

  always @(negedge clk) begin
    if (!nRST) begin
      ack = 1'b0; prev_stb = 1'b0; prev_ack = 1'b0; prev_cyc = 1'b0; prev_irq = 1'b0; ten = 0;
    end else begin
      tick++;
      case (ack_mode)
        0:       ack_n = stb;
        1:       ack_n = 1'b0;
        default: ack_n = stb && (tick % 3 == 0);
      endcase
      if (stb && (sel != 4'hF || !we || !cyc || !lock)) proto_viol++;
      if (!stb && (cyc || lock)) proto_viol++;
      if (prev_stb && !prev_ack && !stb) proto_viol++;
      if (stb && ack_n) begin
        cap_adr.push_back(adr);
        cap_dat.push_back(dat);
        ten++;
      end
      if (prev_cyc && !cyc) begin
        if (ten > BL) proto_viol++;
        if (ten == BL) full_bursts++;
        ten = 0;
      end
      if (irq) begin
        irq_total++;
        if (prev_irq) proto_viol++;
      end
      prev_stb = stb; prev_ack = ack_n; prev_cyc = cyc; prev_irq = irq;
      ack = ack_n;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_ctl"}, {26'b0, stb, cyc, lock, we, irq, ovf}, 32'h0);
    check({tag, "_sel"}, {28'b0, sel}, 32'h0);
    check({tag, "_adr"}, adr, 32'h0);
    check({tag, "_dat"}, dat, 32'h0);
  endtask

  task automatic run_frame(input logic [31:0] base, input logic c0, input logic c1,
                           input int lines, input int ppl, input logic [7:0] p0);
    logic [7:0] pv;
    pv = p0;
    wb_reg_data = base;
    wb_reg_ctr  = {31'b0, c0};
    @(posedge clk); #1 pe = 1'b1; fv = 1'b1; lv = 1'b0;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        @(posedge clk); #1 lv = 1'b1; pix = pv; pv = pv + 8'd1;
      end
      @(posedge clk); #1 lv = 1'b0; pix = 8'h00;
      if (l == 0) wb_reg_ctr = {31'b0, c1};
      @(posedge clk); #1;
    end
    @(posedge clk); #1 fv = 1'b0;
    @(posedge clk); #1 pe = 1'b0;
  endtask

  typedef struct {
    logic [31:0] base;
    logic        ctr;
    int          lines;
    int          ppl;
    logic [7:0]  pix0;
    int          mode;
    int          exp_wr;
    int          exp_irq;
    logic        exp_ovf;
    logic [31:0] a0, d0, al, dl;
    int          exp_fb;
  } vec_t;

  vec_t vt[6];
  int   n0, i0, p0, f0, waited;

  initial begin
    vt[0] = '{32'h1000, 1'b1, 2, 8, 8'h00, 0, 4, 1, 1'b0, 32'h1000, 32'h03020100, 32'h100C, 32'h0F0E0D0C, -1};
    vt[1] = '{32'h1800, 1'b0, 2, 8, 8'h00, 0, 0, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, -1};
    vt[2] = '{32'h2000, 1'b1, 1, 6, 8'hA1, 0, 2, 1, 1'b0, 32'h2000, 32'hA4A3A2A1, 32'h2004, 32'h0000A6A5, -1};
    vt[3] = '{32'h3000, 1'b1, 13, 8, 8'h00, 0, 24, 1, 1'b1, 32'h3000, 32'h03020100, 32'h305C, 32'h5F5E5D5C, -1};
    vt[4] = '{32'h4003, 1'b1, 1, 4, 8'h10, 0, 1, 1, 1'b0, 32'h4000, 32'h13121110, 32'h4000, 32'h13121110, -1};
    vt[5] = '{32'h5000, 1'b1, 8, 8, 8'h40, 2, 16, 1, 1'b0, 32'h5000, 32'h43424140, 32'h503C, 32'h7F7E7D7C, 2};

    nRST = 1'b0; pe = 1'b0; fv = 1'b0; lv = 1'b0; pix = 8'h00;
    wb_reg_data = '0; wb_reg_ctr = '0;
    repeat (3) @(posedge clk);
    #1 outputs_zero("reset");
    nRST = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      ack_mode = vt[i].mode;
      n0 = cap_adr.size(); i0 = irq_total; p0 = proto_viol; f0 = full_bursts;
      run_frame(vt[i].base, vt[i].ctr, vt[i].ctr, vt[i].lines, vt[i].ppl, vt[i].pix0);
      repeat (200) @(posedge clk);
      #1;
      check($sformatf("v%0d_writes", i), 32'(cap_adr.size() - n0), 32'(vt[i].exp_wr));
      check($sformatf("v%0d_irq", i), 32'(irq_total - i0), 32'(vt[i].exp_irq));
      check($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, vt[i].exp_ovf});
      check($sformatf("v%0d_proto", i), 32'(proto_viol - p0), 32'h0);
      if (vt[i].exp_wr > 0 && cap_adr.size() > n0) begin
        check($sformatf("v%0d_adr0", i), cap_adr[n0], vt[i].a0);
        check($sformatf("v%0d_dat0", i), cap_dat[n0], vt[i].d0);
        check($sformatf("v%0d_adrL", i), cap_adr[cap_adr.size()-1], vt[i].al);
        check($sformatf("v%0d_datL", i), cap_dat[cap_dat.size()-1], vt[i].dl);
      end
      if (vt[i].exp_fb >= 0)
        check($sformatf("v%0d_bursts", i), 32'(full_bursts - f0), 32'(vt[i].exp_fb));
    end

    // Enable raised after the frame started must not arm it
    ack_mode = 0;
    n0 = cap_adr.size(); i0 = irq_total;
    run_frame(32'h9000, 1'b0, 1'b1, 3, 8, 8'h00);
    repeat (100) @(posedge clk);
    #1;
    check("late_en_writes", 32'(cap_adr.size() - n0), 32'h0);
    check("late_en_irq", 32'(irq_total - i0), 32'h0);

    // Back-pressure: ACK held low well past FIFO capacity
    ack_mode = 1;
    n0 = cap_adr.size(); i0 = irq_total; p0 = proto_viol;
    run_frame(32'h6000, 1'b1, 1'b1, 12, 8, 8'h00);
    repeat (80) @(posedge clk);
    #1;
    check("bp_ovf", {31'b0, ovf}, 32'h1);
    check("bp_stb_held", {31'b0, stb}, 32'h1);
    check("bp_no_write", 32'(cap_adr.size() - n0), 32'h0);
    ack_mode = 0;
    repeat (200) @(posedge clk);
    #1;
    check("bp_writes", 32'(cap_adr.size() - n0), 32'd16);
    if (cap_adr.size() > n0) begin
      check("bp_adr0", cap_adr[n0], 32'h6000);
      check("bp_adrL", cap_adr[cap_adr.size()-1], 32'h603C);
      check("bp_datL", cap_dat[cap_dat.size()-1], 32'h3F3E3D3C);
    end
    check("bp_irq", 32'(irq_total - i0), 32'h1);
    check("bp_ovf_sticky", {31'b0, ovf}, 32'h1);
    check("bp_proto", 32'(proto_viol - p0), 32'h0);

    run_frame(32'h6400, 1'b0, 1'b0, 1, 8, 8'h00);
    repeat (50) @(posedge clk);
    #1 check("unarmed_ovf_kept", {31'b0, ovf}, 32'h1);
    n0 = cap_adr.size();
    run_frame(32'h6800, 1'b1, 1'b1, 1, 4, 8'h20);
    repeat (50) @(posedge clk);
    #1;
    check("rearm_ovf_clr", {31'b0, ovf}, 32'h0);
    check("rearm_writes", 32'(cap_adr.size() - n0), 32'h1);
    if (cap_adr.size() > n0) check("rearm_dat", cap_dat[n0], 32'h23222120);

    // Reset while a burst is stalled on the bus
    ack_mode = 1;
    run_frame(32'h7000, 1'b1, 1'b1, 4, 8, 8'h00);
    waited = 0;
    while (!stb && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("rst_mid_stb_seen", {31'b0, stb}, 32'h1);
    @(posedge clk); #2 nRST = 1'b0;
    #1 outputs_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1 nRST = 1'b1;
    ack_mode = 0;
    n0 = cap_adr.size(); i0 = irq_total;
    run_frame(32'h8000, 1'b1, 1'b1, 1, 4, 8'h55);
    repeat (60) @(posedge clk);
    #1;
    check("post_rst_writes", 32'(cap_adr.size() - n0), 32'h1);
    if (cap_adr.size() > n0) begin
      check("post_rst_adr", cap_adr[n0], 32'h8000);
      check("post_rst_dat", cap_dat[n0], 32'h58575655);
    end
    check("post_rst_irq", 32'(irq_total - i0), 32'h1);
    check("post_rst_ovf", {31'b0, ovf}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
